triangle_reg_writer: RTL and testbench
======================================

# triangle_reg_writer

CPU-side register front end for the triangle channel. Accepts byte writes at the four triangle register addresses, holds the three register bytes the channel consumes (linear-counter byte, timer low byte, length-load/timer-high byte), and emits the one-cycle reload strobe a length-load write requires. It also contains the 4-step frame sequencer, which produces the quarter-frame and half-frame ticks that clock the channel's linear and length counters. It sits between the CPU bus decoder and the triangle channel.

## Interface
- STEP_CYCLES, 7457, clock cycles per frame-sequencer step; legal range 2..65535.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- wr_en  in  1  write strobe; one write per cycle in which it is high.
- wr_addr  in  2  register select: 0 = linear byte, 1 = unused, 2 = timer low, 3 = length/timer high.
- wr_data  in  8  write data.
- frame_restart  in  1  restarts the frame sequencer at step 0.
- linear_reg  out  8  {control flag, 7-bit counter reload}.
- timer_lo  out  8  timer bits [7:0].
- len_timer_hi  out  8  {5-bit length index, timer bits [10:8]}.
- reload_strobe  out  1  one-cycle pulse after each wr_addr=3 write.
- quarter_frame  out  1  one-cycle pulse at the end of every step.
- half_frame  out  1  one-cycle pulse at the end of steps 1 and 3.
- frame_step  out  2  current sequencer step, 0..3.

## Operation
- Reset, cycle after reset high: all outputs 0, divider 0, step 0. Reset overrides every other input, including a write or frame_restart in the same cycle.
- Register writes:
  - wr_en=1, addr 0 -> linear_reg = wr_data.
  - wr_en=1, addr 2 -> timer_lo = wr_data.
  - wr_en=1, addr 3 -> len_timer_hi = wr_data and reload_strobe = 1.
  - wr_en=1, addr 1 -> no register change and no strobe.
  - Registers hold their values until rewritten.
- reload_strobe: registered. High in the cycle after a qualifying write and low otherwise. Back-to-back addr-3 writes give a strobe that stays high for the same number of consecutive cycles.
- Divider:
  - Width is ceil(log2(STEP_CYCLES)) bits.
  - Counts 0..STEP_CYCLES-1. At the terminal count it wraps to 0 and the step advances mod 4 (3 -> 0).
- Tick outputs (registered):
  - quarter_frame = 1 in the cycle after the terminal count.
  - half_frame = 1 in that same cycle when the step being ended was 1 or 3.
  - Both are 0 otherwise.
- frame_restart: next cycle, divider = 0 and step = 0, with no tick pulses. Restart wins over a coinciding terminal count, which suppresses the tick. Register writes in the same cycle still take effect.
- The sequencer runs free, independent of register writes.

## Timing
- Write latency is 1 cycle. Write at edge N puts data on the outputs and raises reload_strobe after edge N; the strobe falls after edge N+1 unless another addr-3 write occurs.
- Tick latency: terminal count reached at edge N gives quarter_frame (and half_frame when applicable) high between edges N+1 and N+2.
- Tick spacing:
  - quarter_frame period is STEP_CYCLES cycles.
  - half_frame period is 2*STEP_CYCLES cycles.
  - The first quarter_frame after reset is at cycle STEP_CYCLES + 1.
  - The first half_frame after reset is at cycle 2*STEP_CYCLES + 1.
- frame_step changes in the same cycle that quarter_frame pulses and reflects the new step.
- Reset mid-step discards the partial count. The next tick is STEP_CYCLES cycles after reset releases.

## Test plan
- STEP_CYCLES=4; reset 2 cycles, then release -> all outputs 0; quarter_frame at cycles 5, 9, 13, 17; half_frame at cycles 9 and 17 only; frame_step sequence 1, 2, 3, 0.
- Write addr0=0x94, addr2=0x0A, addr3=0xA0 on consecutive cycles -> linear_reg=0x94, timer_lo=0x0A, len_timer_hi=0xA0, each 1 cycle after its write; reload_strobe high exactly 1 cycle, after the addr3 write.
- Write addr1=0xFF -> all registers unchanged, reload_strobe stays 0.
- Two consecutive addr3 writes (0x11 then 0x22) -> reload_strobe high 2 cycles; len_timer_hi ends at 0x22.
- Assert frame_restart on a terminal-count cycle at step 1 -> no quarter_frame or half_frame pulse; frame_step=0; next quarter_frame 4 cycles later with frame_step=1.
- Assert reset during step 2 with linear_reg=0x94 -> next cycle all outputs 0; quarter_frame 4 cycles after release.

Source files
------------

// File: rtl/triangle_reg_writer.sv
// Triangle channel CPU register front end: latches the three register bytes,
// emits the length-reload strobe, and runs the 4-step frame sequencer.
module triangle_reg_writer #(
  parameter int unsigned STEP_CYCLES = 7457
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       frame_restart,
  output logic [7:0] linear_reg,
  output logic [7:0] timer_lo,
  output logic [7:0] len_timer_hi,
  output logic       reload_strobe,
  output logic       quarter_frame,
  output logic       half_frame,
  output logic [1:0] frame_step
);

  localparam int unsigned DIV_W = $clog2(STEP_CYCLES);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {
    ADDR_LINEAR = 2'd0,
    ADDR_UNUSED = 2'd1,
    ADDR_TIMER_LO = 2'd2,
    ADDR_LEN_HI = 2'd3
  } reg_addr_e;

  logic [7:0]       linear_q, linear_d;
  logic [7:0]       timer_lo_q, timer_lo_d;
  logic [7:0]       len_hi_q, len_hi_d;
  logic             strobe_q, strobe_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       step_q, step_d;
  logic             qf_q, qf_d;
  logic             hf_q, hf_d;
  reg_addr_e        addr;

  assign addr = reg_addr_e'(wr_addr);

  // Register file: writes are independent of the sequencer and of restart.
  always_comb begin
    // NOTE: every next-state value gets a hold default first, so no path through
    // the case leaves a signal unassigned and no latch is inferred.
    linear_d   = linear_q;
    timer_lo_d = timer_lo_q;
    len_hi_d   = len_hi_q;
    strobe_d   = 1'b0;
    if (wr_en) begin
      unique case (addr)
        ADDR_LINEAR:   linear_d = wr_data;
        ADDR_TIMER_LO: timer_lo_d = wr_data;
        ADDR_LEN_HI: begin
          len_hi_d = wr_data;
          strobe_d = 1'b1;
        end
        ADDR_UNUSED:   ;
        default:       ;
      endcase
    end
  end

  // Frame sequencer; a restart wins over a coinciding terminal count and
  // swallows its tick.
  always_comb begin
    div_d  = div_q + DIV_W'(1);
    step_d = step_q;
    qf_d   = 1'b0;
    hf_d   = 1'b0;
    if (frame_restart) begin
      div_d  = '0;
      step_d = 2'd0;
    end else if (div_q == DIV_LAST) begin
      div_d  = '0;
      step_d = step_q + 2'd1;
      qf_d   = 1'b1;
      hf_d   = step_q[0];  // steps 1 and 3 end a half frame
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      linear_q   <= '0;
      timer_lo_q <= '0;
      len_hi_q   <= '0;
      strobe_q   <= 1'b0;
      div_q      <= '0;
      step_q     <= 2'd0;
      qf_q       <= 1'b0;
      hf_q       <= 1'b0;
    end else begin
      linear_q   <= linear_d;
      timer_lo_q <= timer_lo_d;
      len_hi_q   <= len_hi_d;
      strobe_q   <= strobe_d;
      div_q      <= div_d;
      step_q     <= step_d;
      qf_q       <= qf_d;
      hf_q       <= hf_d;
    end
  end

  assign linear_reg    = linear_q;
  assign timer_lo      = timer_lo_q;
  assign len_timer_hi  = len_hi_q;
  assign reload_strobe = strobe_q;
  assign quarter_frame = qf_q;
  assign half_frame    = hf_q;
  assign frame_step    = step_q;

endmodule

// File: tb/tb_triangle_reg_writer.sv
// Directed bench for triangle_reg_writer with STEP_CYCLES=4; cycle numbers
// count from the first cycle after reset releases (cycle 1).
module tb_triangle_reg_writer;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_restart;
  logic [7:0] linear_reg;
  logic [7:0] timer_lo;
  logic [7:0] len_timer_hi;
  logic       reload_strobe;
  logic       quarter_frame;
  logic       half_frame;
  logic [1:0] frame_step;

  int pass_cnt = 0;
  int total_cnt = 0;

  triangle_reg_writer #(.STEP_CYCLES(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .frame_restart (frame_restart),
    .linear_reg    (linear_reg),
    .timer_lo      (timer_lo),
    .len_timer_hi  (len_timer_hi),
    .reload_strobe (reload_strobe),
    .quarter_frame (quarter_frame),
    .half_frame    (half_frame),
    .frame_step    (frame_step)
  );

  always #5 clk = ~clk;

  // Advance one edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wr_en = 1'b0;
    frame_restart = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] got;
    wr_en = 1'b0; wr_addr = 2'd0; wr_data = 8'h00; frame_restart = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    got = {linear_reg, timer_lo, len_timer_hi, reload_strobe, quarter_frame, half_frame, frame_step} == '0 ? 13'd0 : 13'd1;
    total_cnt++;
    if (got !== 13'd0)
      $display("FAIL reset_outputs: lin=%h tlo=%h lhi=%h rs=%b qf=%b hf=%b step=%0d, want all 0",
               linear_reg, timer_lo, len_timer_hi, reload_strobe, quarter_frame, half_frame, frame_step);
    else pass_cnt++;
    for (int cyc = 2; cyc <= 20; cyc++) begin
      logic exp_qf, exp_hf;
      logic [1:0] exp_step;
      tick();
      exp_qf = (cyc == 5) || (cyc == 9) || (cyc == 13) || (cyc == 17);
      exp_hf = (cyc == 9) || (cyc == 17);
      exp_step = (cyc < 5) ? 2'd0 : 2'((cyc - 5) / 4 + 1);
      total_cnt++;
      if (quarter_frame !== exp_qf || half_frame !== exp_hf || frame_step !== exp_step)
        $display("FAIL ticks_cycle_%0d: qf=%b hf=%b step=%0d, want qf=%b hf=%b step=%0d",
                 cyc, quarter_frame, half_frame, frame_step, exp_qf, exp_hf, exp_step);
      else pass_cnt++;
    end
  endtask

  task automatic test_writes();
    do_reset();
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'h94;
    tick();
    total_cnt++;
    if (linear_reg !== 8'h94 || reload_strobe !== 1'b0)
      $display("FAIL write_linear: lin=%h rs=%b, want 94 0", linear_reg, reload_strobe);
    else pass_cnt++;
    wr_addr = 2'd2; wr_data = 8'h0A;
    tick();
    total_cnt++;
    if (timer_lo !== 8'h0A || reload_strobe !== 1'b0)
      $display("FAIL write_timer_lo: tlo=%h rs=%b, want 0a 0", timer_lo, reload_strobe);
    else pass_cnt++;
    wr_addr = 2'd3; wr_data = 8'hA0;
    tick();
    total_cnt++;
    if (len_timer_hi !== 8'hA0 || reload_strobe !== 1'b1 || linear_reg !== 8'h94)
      $display("FAIL write_len_hi: lhi=%h rs=%b lin=%h, want a0 1 94", len_timer_hi, reload_strobe, linear_reg);
    else pass_cnt++;
    wr_en = 1'b0;
    tick();
    // Cycle 5: strobe gone, sequencer ticked regardless of the writes.
    total_cnt++;
    if (reload_strobe !== 1'b0 || quarter_frame !== 1'b1 || frame_step !== 2'd1)
      $display("FAIL strobe_fall: rs=%b qf=%b step=%0d, want 0 1 1", reload_strobe, quarter_frame, frame_step);
    else pass_cnt++;
  endtask

  task automatic test_unused_addr();
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'hFF;
    tick();
    wr_en = 1'b0;
    total_cnt++;
    if (linear_reg !== 8'h94 || timer_lo !== 8'h0A || len_timer_hi !== 8'hA0 || reload_strobe !== 1'b0)
      $display("FAIL unused_addr: lin=%h tlo=%h lhi=%h rs=%b, want 94 0a a0 0",
               linear_reg, timer_lo, len_timer_hi, reload_strobe);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (reload_strobe !== 1'b0)
      $display("FAIL unused_addr_strobe: rs=%b, want 0", reload_strobe);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    wr_en = 1'b1; wr_addr = 2'd3; wr_data = 8'h11;
    tick();
    total_cnt++;
    if (reload_strobe !== 1'b1 || len_timer_hi !== 8'h11)
      $display("FAIL b2b_first: rs=%b lhi=%h, want 1 11", reload_strobe, len_timer_hi);
    else pass_cnt++;
    wr_data = 8'h22;
    tick();
    total_cnt++;
    if (reload_strobe !== 1'b1 || len_timer_hi !== 8'h22)
      $display("FAIL b2b_second: rs=%b lhi=%h, want 1 22", reload_strobe, len_timer_hi);
    else pass_cnt++;
    wr_en = 1'b0;
    tick();
    total_cnt++;
    if (reload_strobe !== 1'b0 || len_timer_hi !== 8'h22)
      $display("FAIL b2b_end: rs=%b lhi=%h, want 0 22", reload_strobe, len_timer_hi);
    else pass_cnt++;
  endtask

  task automatic test_restart();
    do_reset();
    // Cycle 1 -> cycle 8: terminal count of step 1.
    for (int i = 0; i < 7; i++) tick();
    total_cnt++;
    if (frame_step !== 2'd1 || quarter_frame !== 1'b0)
      $display("FAIL restart_pre: step=%0d qf=%b, want 1 0", frame_step, quarter_frame);
    else pass_cnt++;
    frame_restart = 1'b1;
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'h5A;
    tick();
    frame_restart = 1'b0;
    wr_en = 1'b0;
    total_cnt++;
    if (quarter_frame !== 1'b0 || half_frame !== 1'b0 || frame_step !== 2'd0 || linear_reg !== 8'h5A)
      $display("FAIL restart_suppress: qf=%b hf=%b step=%0d lin=%h, want 0 0 0 5a",
               quarter_frame, half_frame, frame_step, linear_reg);
    else pass_cnt++;
    for (int i = 1; i <= 4; i++) begin
      tick();
      total_cnt++;
      if (quarter_frame !== (i == 4) || half_frame !== 1'b0 || frame_step !== ((i == 4) ? 2'd1 : 2'd0))
        $display("FAIL restart_after_%0d: qf=%b hf=%b step=%0d, want qf=%b hf=0 step=%0d",
                 i, quarter_frame, half_frame, frame_step, (i == 4), (i == 4) ? 1 : 0);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_step();
    do_reset();
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'h94;
    tick();
    wr_en = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    // Cycle 10: inside step 2.
    total_cnt++;
    if (frame_step !== 2'd2 || linear_reg !== 8'h94)
      $display("FAIL midreset_pre: step=%0d lin=%h, want 2 94", frame_step, linear_reg);
    else pass_cnt++;
    reset = 1'b1;
    wr_en = 1'b1; wr_addr = 2'd3; wr_data = 8'h33;
    frame_restart = 1'b1;
    tick();
    reset = 1'b0; wr_en = 1'b0; frame_restart = 1'b0;
    total_cnt++;
    if (linear_reg !== 8'h00 || timer_lo !== 8'h00 || len_timer_hi !== 8'h00 || reload_strobe !== 1'b0 ||
        quarter_frame !== 1'b0 || half_frame !== 1'b0 || frame_step !== 2'd0)
      $display("FAIL midreset_outputs: lin=%h tlo=%h lhi=%h rs=%b qf=%b hf=%b step=%0d, want all 0",
               linear_reg, timer_lo, len_timer_hi, reload_strobe, quarter_frame, half_frame, frame_step);
    else pass_cnt++;
    for (int i = 1; i <= 4; i++) begin
      tick();
      total_cnt++;
      if (quarter_frame !== (i == 4))
        $display("FAIL midreset_tick_%0d: qf=%b, want %b", i, quarter_frame, (i == 4));
      else pass_cnt++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, want bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_writes();
    test_unused_addr();
    test_back_to_back();
    test_restart();
    test_reset_mid_step();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
